// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: drives a req/gnt/rvalid data bus, aligns load data and
// reports misaligned, illegal and timed-out accesses to WB through a one-cycle pulse.
module mem_stage_lsu #(
   parameter int TIMEOUT_CYC = 256,
   parameter int TIMEOUT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [31:0] wb_data,
   output logic [1:0]  wb_exc
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t               state_reg, state_next;
   logic [31:0]          addr_reg, sd_reg;
   logic [2:0]           f3_reg;
   logic [4:0]           rd_reg;
   logic                 rw_reg, load_reg, store_reg;
   logic [TIMEOUT_W-1:0] cnt_reg;

   logic        accept, is_mem, illegal, misaligned, timeout_hit;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   assign ex_ready    = (state_reg == IDLE);
   assign accept      = ex_valid && ex_ready;
   assign is_mem      = ex_is_load || ex_is_store;
   assign illegal     = (ex_is_load && ex_is_store)
                      || (ex_is_load && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
                      || (ex_is_store && (ex_funct3[2] || ex_funct3 == 3'b011));
   assign misaligned  = is_mem && (((ex_funct3[1:0] == 2'b01) && ex_alu_result[0])
                      || ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00)));
   assign timeout_hit = (cnt_reg == TIMEOUT_W'(TIMEOUT_CYC - 1));

   // Bus signals come straight from latched state so they stay stable until gnt.
   assign dmem_req  = (state_reg == REQ);
   assign dmem_we   = store_reg;
   assign dmem_addr = {addr_reg[31:2], 2'b00};

   always_comb begin
      dmem_be = 4'b1111;
      case (f3_reg[1:0])
         2'b00:   dmem_be = 4'b0001 << addr_reg[1:0];
         2'b01:   dmem_be = addr_reg[1] ? 4'b1100 : 4'b0011;
         default: dmem_be = 4'b1111;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign dmem_wdata[8*gi +: 8] = (f3_reg[1:0] == 2'b10) ? sd_reg[8*gi +: 8] :
                                     (f3_reg[1:0] == 2'b01) ? sd_reg[8*(gi%2) +: 8] :
                                                              sd_reg[7:0];
   end

   assign ld_byte = dmem_rdata[{addr_reg[1:0], 3'b000} +: 8];
   assign ld_half = addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      load_data = dmem_rdata;
      case (f3_reg[1:0])
         2'b00:   load_data = {{24{~f3_reg[2] & ld_byte[7]}}, ld_byte};
         2'b01:   load_data = {{16{~f3_reg[2] & ld_half[15]}}, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   // Completion takes priority over the timeout; a load gnt on the last cycle still times out.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept && is_mem && !illegal && !misaligned) state_next = REQ;
         REQ: begin
            if (dmem_gnt && store_reg) state_next = IDLE;
            else if (timeout_hit)      state_next = IDLE;
            else if (dmem_gnt)         state_next = WAIT;
         end
         WAIT: if (dmem_rvalid || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         sd_reg       <= '0;
         f3_reg       <= '0;
         rd_reg       <= '0;
         rw_reg       <= 1'b0;
         load_reg     <= 1'b0;
         store_reg    <= 1'b0;
         cnt_reg      <= '0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         wb_data      <= '0;
         wb_exc       <= '0;
      end else begin
         state_reg <= state_next;
         wb_valid  <= 1'b0;
         cnt_reg   <= (state_reg == IDLE) ? '0 : cnt_reg + TIMEOUT_W'(1);
         case (state_reg)
            IDLE: if (accept) begin
               addr_reg  <= ex_alu_result;
               sd_reg    <= ex_store_data;
               f3_reg    <= ex_funct3;
               rd_reg    <= ex_rd;
               rw_reg    <= ex_reg_write;
               load_reg  <= ex_is_load;
               store_reg <= ex_is_store;
               if (illegal || misaligned || !is_mem) begin
                  wb_valid     <= 1'b1;
                  wb_rd        <= ex_rd;
                  wb_data      <= ex_alu_result;
                  wb_exc       <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
                  wb_reg_write <= !illegal && !misaligned && ex_reg_write;
               end
            end
            REQ: if ((dmem_gnt && store_reg) || timeout_hit) begin
               wb_valid     <= 1'b1;
               wb_rd        <= rd_reg;
               wb_reg_write <= 1'b0;
               wb_exc       <= (dmem_gnt && store_reg) ? 2'b00 : 2'b10;
               if (!(dmem_gnt && store_reg)) wb_data <= addr_reg;
            end
            WAIT: if (dmem_rvalid || timeout_hit) begin
               wb_valid     <= 1'b1;
               wb_rd        <= rd_reg;
               wb_reg_write <= dmem_rvalid && rw_reg && load_reg;
               wb_exc       <= dmem_rvalid ? 2'b00 : 2'b10;
               wb_data      <= dmem_rvalid ? load_data : addr_reg;
            end
            default: ;
         endcase
      end
   end

endmodule
